// File: rtl/pk_decode_stream_pkg.sv
// Shared constants, FSM state type and width helper for the public-key
// stream decoder.
package pk_decode_pkg;

  localparam int RHO_BYTES  = 32;
  localparam int POLY_BYTES = 320;
  localparam int T1_BITS    = 10;

  typedef enum logic [2:0] {
    IDLE,
    RHO,
    T1_FILL,
    T1_OUT,
    DONE
  } state_t;

  // Index width for n items; never collapses to zero bits.
  function automatic int bitlen(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pk_decode_stream_if.sv
// Byte-stream input, rho and t1 polynomial output bundle of the decoder.
interface pk_decode_stream_if #(
    parameter int K       = 6,
    parameter int T1_BITS = 10
);
    localparam int IDX_W  = pk_decode_pkg::bitlen(K);
    localparam int POLY_W = 32 * T1_BITS * 8;

    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [255:0]      rho;
    logic              rho_valid;
    logic [POLY_W-1:0] poly_data;
    logic [IDX_W-1:0]  poly_idx;
    logic              poly_valid;
    logic              poly_ready;
    logic              busy;
    logic              done;

    modport slave (
        input  start, in_data, in_valid, poly_ready,
        output in_ready, rho, rho_valid, poly_data, poly_idx, poly_valid,
               busy, done
    );

    modport master (
        output start, in_data, in_valid, poly_ready,
        input  in_ready, rho, rho_valid, poly_data, poly_idx, poly_valid,
               busy, done
    );
endinterface

// File: rtl/pk_decode_stream_byte_shift_reg.sv
// Byte-wide shift register: each loaded byte enters at the LSB, so the first
// byte of a sequence ends up at the MSB.
module byte_shift_reg #(
    parameter int NBYTES = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  load,
    input  logic [7:0]            din,
    output logic [NBYTES*8-1:0]   q
);
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            q <= '0;
        end else if (load) begin
            q <= {q[NBYTES*8-9:0], din};
        end
    end
endmodule

// File: rtl/pk_decode_stream.sv
// Splits an ML-DSA public-key byte stream into the rho seed and K packed t1
// polynomials, handing each polynomial downstream with a valid/ready handshake.
module pk_decode_stream #(
    parameter int K       = 6,
    parameter int T1_BITS = pk_decode_pkg::T1_BITS
) (
    input  logic                clk,
    input  logic                reset,
    pk_decode_stream_if.slave   bus
);
    import pk_decode_pkg::*;

    localparam int IDX_W    = bitlen(K);
    localparam int POLY_LEN = POLY_BYTES * T1_BITS / pk_decode_pkg::T1_BITS;

    state_t           state_q, state_d;
    logic [8:0]       byte_cnt_q;
    logic [IDX_W-1:0] poly_idx_q;
    logic             rho_valid_q;

    logic in_ready, busy, done, poly_valid;
    logic accept, start_go, rho_last, poly_last, idx_last;

    assign accept    = bus.in_valid && in_ready;
    assign start_go  = (state_q == IDLE) && bus.start;
    assign rho_last  = (byte_cnt_q == 9'(RHO_BYTES - 1));
    assign poly_last = (byte_cnt_q == 9'(POLY_LEN - 1));
    assign idx_last  = (poly_idx_q == IDX_W'(K - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake outputs decode only the registered state, never in_valid.
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        poly_valid = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (bus.start) state_d = RHO;
            end
            RHO: begin
                in_ready = 1'b1;
                if (bus.in_valid && rho_last) state_d = T1_FILL;
            end
            T1_FILL: begin
                in_ready = 1'b1;
                if (bus.in_valid && poly_last) state_d = T1_OUT;
            end
            T1_OUT: begin
                poly_valid = 1'b1;
                if (bus.poly_ready) state_d = idx_last ? DONE : T1_FILL;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt_q  <= '0;
            poly_idx_q  <= '0;
            rho_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        byte_cnt_q  <= '0;
                        poly_idx_q  <= '0;
                        rho_valid_q <= 1'b0;
                    end
                end
                RHO: begin
                    if (accept) begin
                        byte_cnt_q <= rho_last ? '0 : byte_cnt_q + 9'd1;
                        if (rho_last) rho_valid_q <= 1'b1;
                    end
                end
                T1_FILL: begin
                    if (accept) byte_cnt_q <= poly_last ? '0 : byte_cnt_q + 9'd1;
                end
                T1_OUT: begin
                    if (bus.poly_ready && !idx_last) begin
                        poly_idx_q <= poly_idx_q + IDX_W'(1);
                        byte_cnt_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    byte_shift_reg #(.NBYTES(RHO_BYTES)) u_rho_sr (
        .clk   (clk),
        .reset (reset),
        .clear (start_go),
        .load  (accept && (state_q == RHO)),
        .din   (bus.in_data),
        .q     (bus.rho)
    );

    byte_shift_reg #(.NBYTES(POLY_LEN)) u_poly_sr (
        .clk   (clk),
        .reset (reset),
        .clear (start_go),
        .load  (accept && (state_q == T1_FILL)),
        .din   (bus.in_data),
        .q     (bus.poly_data)
    );

    assign bus.in_ready   = in_ready;
    assign bus.rho_valid  = rho_valid_q;
    assign bus.poly_idx   = poly_idx_q;
    assign bus.poly_valid = poly_valid;
    assign bus.busy       = busy;
    assign bus.done       = done;
endmodule
